hilo_control: RTL and testbench

// - Sequencer and HI/LO register owner for the multicycle MULT/DIV units. Sits between
//   the CPU control unit and the divider/multiplier: latches operands, pulses the unit's

---
 rtl/hilo_pkg.sv | 19 +
 rtl/hilo_control.sv | 140 ++++++++++++++
 tb/tb_hilo_control.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op_sel and sequencer state encodings for hilo_control
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_EXC    = 3'd4
    } state_e;

endpackage

// File: rtl/hilo_control.sv
// rtl/hilo_control.sv - MULT/DIV sequencer and architectural HI/LO owner
module hilo_control
    import hilo_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             div_end_i,
    input  logic [WIDTH-1:0] div_hi_i,
    input  logic [WIDTH-1:0] div_lo_i,
    input  logic             mult_end_i,
    input  logic [WIDTH-1:0] mult_hi_i,
    input  logic [WIDTH-1:0] mult_lo_i,
    output logic             div_start_o,
    output logic             mult_start_o,
    output logic [WIDTH-1:0] operand_a_o,
    output logic [WIDTH-1:0] operand_b_o,
    output logic             busy,
    output logic             done,
    output logic             div0_exception,
    output logic             timeout_error,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unit_div_q, unit_div_d;
    logic             exc_div0_q, exc_div0_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             end_sel;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            unit_div_q <= 1'b0;
            exc_div0_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            unit_div_q <= unit_div_d;
            exc_div0_q <= exc_div0_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        unit_div_d = unit_div_q;
        exc_div0_d = exc_div0_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        end_sel    = unit_div_q ? div_end_i : mult_end_i;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    case (op_e'(op_sel))
                        OP_MULT, OP_DIV: begin
                            // Divide-by-zero never reaches the divider.
                            if (op_e'(op_sel) == OP_DIV && rt_data == '0) begin
                                exc_div0_d = 1'b1;
                                state_d    = ST_EXC;
                            end else begin
                                opa_d      = rs_data;
                                opb_d      = rt_data;
                                unit_div_d = (op_e'(op_sel) == OP_DIV);
                                state_d    = ST_LAUNCH;
                            end
                        end
                        OP_MTHI: begin
                            hi_d    = rs_data;
                            state_d = ST_COMMIT;
                        end
                        OP_MTLO: begin
                            lo_d    = rs_data;
                            state_d = ST_COMMIT;
                        end
                    endcase
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // cnt_q == 0 is the first WAIT edge: the end level may still be
                // left over from the unit's previous operation.
                if (cnt_q != '0 && end_sel) begin
                    hi_d    = unit_div_q ? div_hi_i : mult_hi_i;
                    lo_d    = unit_div_q ? div_lo_i : mult_lo_i;
                    state_d = ST_COMMIT;
                end else if (cnt_q == CNT_MAX) begin
                    exc_div0_d = 1'b0;
                    state_d    = ST_EXC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: state_d = ST_IDLE;
            ST_EXC:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign div_start_o    = (state_q == ST_LAUNCH) &&  unit_div_q;
    assign mult_start_o   = (state_q == ST_LAUNCH) && !unit_div_q;
    assign busy           = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    assign done           = (state_q == ST_COMMIT);
    assign div0_exception = (state_q == ST_EXC) &&  exc_div0_q;
    assign timeout_error  = (state_q == ST_EXC) && !exc_div0_q;
    assign operand_a_o    = opa_q;
    assign operand_b_o    = opb_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;

endmodule

// File: tb/tb_hilo_control.sv
// tb/tb_hilo_control.sv - randomized self-checking bench for hilo_control
module tb_hilo_control;

    localparam int W    = 32;
    localparam int T    = 64;
    localparam int MAXC = 12000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         op_start = 1'b0;
    logic [1:0]   op_sel = 2'b00;
    logic [W-1:0] rs_data = '0, rt_data = '0;
    logic         div_end = 1'b0, mult_end = 1'b0;
    logic [W-1:0] div_hi = '0, div_lo = '0, mult_hi = '0, mult_lo = '0;
    logic         div_start_o, mult_start_o, busy, done, div0_exception, timeout_error;
    logic [W-1:0] operand_a_o, operand_b_o, hi_o, lo_o;

    always #5 clock = ~clock;

    hilo_control #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .op_start(op_start), .op_sel(op_sel),
        .rs_data(rs_data), .rt_data(rt_data),
        .div_end_i(div_end), .div_hi_i(div_hi), .div_lo_i(div_lo),
        .mult_end_i(mult_end), .mult_hi_i(mult_hi), .mult_lo_i(mult_lo),
        .div_start_o(div_start_o), .mult_start_o(mult_start_o),
        .operand_a_o(operand_a_o), .operand_b_o(operand_b_o),
        .busy(busy), .done(done), .div0_exception(div0_exception),
        .timeout_error(timeout_error), .hi_o(hi_o), .lo_o(lo_o)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected per-cycle outputs; index n is the cycle following the n-th rising edge.
    bit           e_busy [MAXC];
    bit           e_done [MAXC];
    bit           e_d0   [MAXC];
    bit           e_to   [MAXC];
    bit           e_ds   [MAXC];
    bit           e_ms   [MAXC];
    bit           hv     [MAXC];
    bit           lv     [MAXC];
    bit           ov     [MAXC];
    logic [W-1:0] hval   [MAXC];
    logic [W-1:0] lval   [MAXC];
    logic [W-1:0] oa     [MAXC];
    logic [W-1:0] ob     [MAXC];
    int           idle_from = 0;
    bit           chk_en = 0;

    int errors = 0, checks = 0;
    int done_cnt = 0, ds_cnt = 0, last_done = -1, last_to = -1, last_d0 = -1;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Behavioural divider / multiplier: results at start, end level after lat edges.
    int   div_lat = 32, mult_lat = 5, div_rem = 0, mult_rem = 0;
    bit   div_lazy = 0, mult_lazy = 0, div_clr = 0, mult_clr = 0;
    always @(posedge clock) begin
        if (div_start_o) begin
            div_rem <= div_lat;
            div_hi  <= (operand_b_o != 0) ? operand_a_o % operand_b_o : '0;
            div_lo  <= (operand_b_o != 0) ? operand_a_o / operand_b_o : '0;
            if (div_lazy) div_clr <= 1'b1;
            else          div_end <= 1'b0;
        end else begin
            if (div_clr) begin
                div_end <= 1'b0;
                div_clr <= 1'b0;
            end
            if (div_rem > 0) begin
                div_rem <= div_rem - 1;
                if (div_rem == 1) div_end <= 1'b1;
            end
        end
    end
    always @(posedge clock) begin
        if (mult_start_o) begin
            mult_rem <= mult_lat;
            {mult_hi, mult_lo} <= {32'b0, operand_a_o} * {32'b0, operand_b_o};
            if (mult_lazy) mult_clr <= 1'b1;
            else           mult_end <= 1'b0;
        end else begin
            if (mult_clr) begin
                mult_end <= 1'b0;
                mult_clr <= 1'b0;
            end
            if (mult_rem > 0) begin
                mult_rem <= mult_rem - 1;
                if (mult_rem == 1) mult_end <= 1'b1;
            end
        end
    end

    initial begin
        logic [W-1:0] cur_hi, cur_lo;
        cur_hi = '0;
        cur_lo = '0;
        forever begin
            @(negedge clock);
            if (chk_en && cyc < MAXC) begin
                if (hv[cyc]) cur_hi = hval[cyc];
                if (lv[cyc]) cur_lo = lval[cyc];
                chk("busy", busy, e_busy[cyc]);
                chk("done", done, e_done[cyc]);
                chk("div0_exception", div0_exception, e_d0[cyc]);
                chk("timeout_error", timeout_error, e_to[cyc]);
                chk("div_start_o", div_start_o, e_ds[cyc]);
                chk("mult_start_o", mult_start_o, e_ms[cyc]);
                chk("hi_o", hi_o, cur_hi);
                chk("lo_o", lo_o, cur_lo);
                if (ov[cyc]) begin
                    chk("operand_a_o", operand_a_o, oa[cyc]);
                    chk("operand_b_o", operand_b_o, ob[cyc]);
                end
                if (done) begin
                    done_cnt++;
                    last_done = cyc;
                end
                if (timeout_error)  last_to = cyc;
                if (div0_exception) last_d0 = cyc;
                if (div_start_o)    ds_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        int e;
        e = cyc + 1;
        reset = 1'b1;
        for (int i = e; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_d0[i] = 0; e_to[i] = 0;
            e_ds[i] = 0; e_ms[i] = 0; hv[i] = 0; lv[i] = 0; ov[i] = 0;
        end
        hv[e] = 1; hval[e] = '0;
        lv[e] = 1; lval[e] = '0;
        ov[e] = 1; oa[e] = '0; ob[e] = '0;
        idle_from = e;
        step(1);
        chk_en = 1;
        reset  = 1'b0;
    endtask

    // Drives one op_start cycle; the model decides acceptance from its own idle window.
    task automatic issue(input logic [1:0] sel, input logic [W-1:0] rs, input logic [W-1:0] rt,
                         input int lat, input bit lazy, output int e);
        int          cend;
        bit          ok;
        logic [63:0] p;
        e = cyc + 1;
        op_start = 1'b1;
        op_sel   = sel;
        rs_data  = rs;
        rt_data  = rt;
        if (e - 1 >= idle_from) begin
            if (sel == 2'b10) begin
                hv[e] = 1; hval[e] = rs; e_done[e] = 1; idle_from = e + 1;
            end else if (sel == 2'b11) begin
                lv[e] = 1; lval[e] = rs; e_done[e] = 1; idle_from = e + 1;
            end else if (sel == 2'b01 && rt == 0) begin
                e_d0[e] = 1; idle_from = e + 1;
            end else begin
                ok   = (lat >= 1 && lat <= T);
                cend = ok ? e + 2 + lat : e + 2 + T;
                if (sel == 2'b01) begin
                    div_lat = lat; div_lazy = lazy; e_ds[e] = 1;
                    p = {rs % rt, rs / rt};
                end else begin
                    mult_lat = lat; mult_lazy = lazy; e_ms[e] = 1;
                    p = {32'b0, rs} * {32'b0, rt};
                end
                for (int i = e; i < cend; i++) e_busy[i] = 1;
                for (int i = e; i <= cend; i++) begin
                    ov[i] = 1; oa[i] = rs; ob[i] = rt;
                end
                if (ok) begin
                    e_done[cend] = 1;
                    hv[cend] = 1; hval[cend] = p[63:32];
                    lv[cend] = 1; lval[cend] = p[31:0];
                end else begin
                    e_to[cend] = 1;
                end
                idle_from = cend + 1;
            end
        end
        step(1);
        op_start = 1'b0;
        rs_data  = $urandom;
        rt_data  = $urandom;
    endtask

    initial begin
        int e, e2, d0, s0;
        step(1);
        do_reset();
        step(1);
        chk("reset_hi", hi_o, 32'h0);
        chk("reset_lo", lo_o, 32'h0);

        s0 = ds_cnt;
        issue(2'b01, 32'd100, 32'd7, 32, 0, e);
        step(40);
        chk("div_done_latency", 32'(last_done - e), 32'd34);
        chk("div_lo_quot", lo_o, 32'd14);
        chk("div_hi_rem", hi_o, 32'd2);
        chk("div_start_pulses", 32'(ds_cnt - s0), 32'd1);

        s0 = ds_cnt;
        issue(2'b01, 32'd55, 32'd0, 1, 0, e);
        step(3);
        chk("div0_at_e0", 32'(last_d0 - e), 32'd0);
        chk("div0_no_start", 32'(ds_cnt - s0), 32'd0);
        chk("div0_hi_kept", hi_o, 32'd2);

        issue(2'b10, 32'hDEADBEEF, 32'h0, 1, 0, e);
        step(2);
        chk("mthi_done", 32'(last_done - e), 32'd0);
        issue(2'b11, 32'h12345678, 32'h0, 1, 0, e);
        step(2);
        chk("mthi_hi", hi_o, 32'hDEADBEEF);
        chk("mtlo_lo", lo_o, 32'h12345678);

        issue(2'b00, 32'd9, 32'd9, 0, 0, e);
        step(T + 6);
        chk("mult_timeout_at", 32'(last_to - e), 32'(T + 2));
        chk("timeout_hi_kept", hi_o, 32'hDEADBEEF);

        d0 = done_cnt;
        issue(2'b01, 32'd1000, 32'd3, 32, 0, e);
        step(10);
        do_reset();
        step(40);
        chk("reset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("reset_hi_zero", hi_o, 32'h0);

        d0 = done_cnt;
        issue(2'b01, 32'd50, 32'd5, 10, 0, e);
        issue(2'b10, 32'hAAAA, 32'h0, 1, 0, e2);
        issue(2'b00, 32'd3, 32'd4, 2, 0, e2);
        step(20);
        chk("busy_ignore_done", 32'(done_cnt - d0), 32'd1);
        chk("busy_ignore_lo", lo_o, 32'd10);

        issue(2'b01, 32'd77, 32'd11, 3, 1, e);
        step(10);
        chk("stale_end_ignored", 32'(last_done - e), 32'd5);

        issue(2'b00, 32'd6, 32'd7, T, 0, e);
        step(T + 6);
        chk("lat_eq_timeout_done", 32'(last_done - e), 32'(T + 2));
        chk("lat_eq_timeout_lo", lo_o, 32'd42);
        issue(2'b01, 32'd6, 32'd7, T + 1, 0, e);
        step(T + 6);
        chk("lat_over_timeout", 32'(last_to - e), 32'(T + 2));

        for (int it = 0; it < 900 && cyc < MAXC - 300; it++) begin
            int           lat, k;
            bit           lazy;
            logic [1:0]   sel;
            logic [W-1:0] rs, rt;
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                sel = 2'($urandom_range(0, 3));
                rs  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 300));
                if ($urandom_range(0, 3) == 0)      rt = '0;
                else if ($urandom_range(0, 1) != 0) rt = 32'($urandom_range(1, 20));
                else                                rt = $urandom;
                k = $urandom_range(0, 9);
                if (k == 0)      lat = 0;
                else if (k == 1) lat = T + $urandom_range(0, 1);
                else             lat = $urandom_range(1, 40);
                lazy = (lat >= 2) && ($urandom_range(0, 1) != 0);
                issue(sel, rs, rt, lat, lazy, e);
            end
            step($urandom_range(0, 4));
        end
        step(T + 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
